// File: rtl/subservient_uart_loader.sv
// subservient_uart_loader: UART 8N1 receiver that writes little-endian words over debug Wishbone, then releases the core.
// Optional idle-line early release when SUBSERVIENT_LOADER_TIMEOUT_EN is defined.
module subservient_uart_loader #(
    parameter int CLK_DIV        = 868,
    parameter int NUM_WORDS      = 128,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    output logic        o_debug_mode,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic        i_wb_dbg_ack,
    output logic        o_done,
    output logic        o_err
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_WORDS + 1);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} ld_state_t;
    rx_state_t rx_state, rx_next;
    ld_state_t ld_state, ld_next;
    logic rx_s1, rx_s2, rx_q;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] sh;
    logic [1:0] byte_cnt;
    logic [23:0] word;
    logic [IW-1:0] idx;
    logic tick, byte_ok, frame_err, word_done, timeout;
    assign tick = cnt == '0;
    assign word_done = byte_ok && byte_cnt == 2'd3;
    assign o_wb_dbg_stb = ld_state == S_WRITE;
    assign o_wb_dbg_we = o_wb_dbg_stb;
    assign o_wb_dbg_sel = 4'hf;
    assign o_debug_mode = ld_state != S_DONE;
    assign o_done = ld_state == S_DONE;
    always_comb begin
        rx_next = rx_state;
        byte_ok = 1'b0;
        frame_err = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_q && !rx_s2 && ld_state != S_DONE) rx_next = RX_START;
            RX_START: if (tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (tick) begin
                    rx_next = RX_IDLE;
                    byte_ok = rx_s2 && ld_state != S_DONE;
                    frame_err = !rx_s2 && ld_state != S_DONE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q <= 1'b1;
            rx_state <= RX_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            sh <= '0;
        end else begin
            rx_s1 <= i_rx;
            rx_s2 <= rx_s1;
            rx_q <= rx_s2;
            rx_state <= rx_next;
            cnt <= (rx_state == RX_IDLE) ? CW'(CLK_DIV / 2 - 1) : tick ? CW'(CLK_DIV - 1) : cnt - CW'(1);
            if (rx_state == RX_START) begin
                bit_idx <= '0;
            end else if (rx_state == RX_DATA && tick) begin
                sh <= {rx_s2, sh[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end
    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            S_LOAD:  ld_next = word_done ? S_WRITE : timeout ? S_DONE : S_LOAD;
            S_WRITE: if (i_wb_dbg_ack) ld_next = (idx == IW'(NUM_WORDS - 1)) ? S_DONE : S_LOAD;
            default: ld_next = ld_state;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ld_state <= S_LOAD;
            idx <= '0;
            byte_cnt <= '0;
            word <= '0;
            o_wb_dbg_adr <= '0;
            o_wb_dbg_dat <= '0;
            o_err <= 1'b0;
        end else begin
            ld_state <= ld_next;
            if (timeout)
                byte_cnt <= '0;
            else if (byte_ok)
                byte_cnt <= byte_cnt + 2'd1;
            if (byte_ok && byte_cnt != 2'd3)
                word[{byte_cnt, 3'b000} +: 8] <= sh;
            if (word_done && ld_state == S_LOAD) begin
                o_wb_dbg_dat <= {sh, word};
                o_wb_dbg_adr <= 32'({idx, 2'b00});
            end
            // A word finishing while the previous write is still pending has nowhere to go
            if ((word_done && ld_state == S_WRITE) || frame_err)
                o_err <= 1'b1;
            if (ld_state == S_WRITE && i_wb_dbg_ack)
                idx <= idx + IW'(1);
        end
    end
`ifdef SUBSERVIENT_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic idle_ok;
    assign idle_ok = ld_state == S_LOAD && idx != '0 && rx_state == RX_IDLE && rx_s2;
    assign timeout = idle_ok && tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            tcnt <= '0;
        else
            tcnt <= idle_ok ? tcnt + TW'(1) : '0;
    end
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_subservient_uart_loader.sv
// tb_subservient_uart_loader: scoreboard bench with a delayed-ack Wishbone responder.
module tb_subservient_uart_loader;
    logic clk = 0, rst_n = 0, rx = 1, ack = 0, stray = 0;
    logic debug_mode, we, stb, done, err;
    logic [31:0] adr, dat;
    logic [3:0] sel;
    int total = 0, bad = 0, nwr = 0, lat = 0, wcnt = 0, base;
    logic [63:0] sb[$];
    logic [63:0] e;

    subservient_uart_loader #(.CLK_DIV(4), .NUM_WORDS(2), .TIMEOUT_CYCLES(200)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_debug_mode(debug_mode),
        .o_wb_dbg_adr(adr), .o_wb_dbg_dat(dat), .o_wb_dbg_sel(sel), .o_wb_dbg_we(we),
        .o_wb_dbg_stb(stb), .i_wb_dbg_ack(ack | stray), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack) begin
            ack = 0;
            chk("stb_drop", 32'(stb), 0);
        end else if (stb) begin
            if (sb.size() == 0) begin
                chk("unexp_stb", 32'(stb), 0);
                ack = 1;
            end else if (wcnt < lat) begin
                wcnt++;
                chk("hold_adr", adr, sb[0][63:32]);
            end else begin
                e = sb.pop_front();
                chk("wr_adr", adr, e[63:32]);
                chk("wr_dat", dat, e[31:0]);
                chk("wr_sel", 32'(sel), 32'hf);
                chk("wr_we", 32'(we), 1);
                nwr++;
                wcnt = 0;
                ack = 1;
            end
        end else wcnt = 0;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (4) @(negedge clk);
        end
        rx = stop;
        repeat (4) @(negedge clk);
        rx = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic wait_wr(input int n);
        for (int i = 0; i < 3000 && nwr < n; i++) @(negedge clk);
        chk("wr_count", 32'(nwr), 32'(n));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_debug", 32'(debug_mode), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat, 0);
        chk("rst_sel", 32'(sel), 32'hf);
        rst_n = 1;
        repeat (2) @(negedge clk);
        // stray ack and rx glitch must not disturb anything
        stray = 1;
        repeat (3) @(negedge clk);
        stray = 0;
        rx = 0;
        @(negedge clk);
        rx = 1;
        repeat (30) @(negedge clk);
        chk("glitch_err", 32'(err), 0);
        chk("glitch_nwr", 32'(nwr), 0);
        // single word with 3-cycle late ack
        lat = 3;
        sb.push_back({32'h0, 32'h00000013});
        send_word(32'h00000013);
        wait_wr(1);
        chk("w1_done", 32'(done), 0);
        // full load of two words
        do_reset();
        lat = 1;
        base = nwr;
        sb.push_back({32'h0, 32'h04030201});
        sb.push_back({32'h4, 32'h08070605});
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_wr(base + 2);
        repeat (3) @(negedge clk);
        chk("full_done", 32'(done), 1);
        chk("full_debug", 32'(debug_mode), 0);
        send_word(32'hdeadbeef);
        repeat (10) @(negedge clk);
        chk("post_done_nwr", 32'(nwr), 32'(base + 2));
        chk("post_done_stb", 32'(stb), 0);
        // framing error then a good word
        do_reset();
        chk("rst2_done", 32'(done), 0);
        base = nwr;
        send_byte(8'h55, 1'b0);
        chk("frame_err", 32'(err), 1);
        sb.push_back({32'h0, 32'h44332211});
        send_word(32'h44332211);
        wait_wr(base + 1);
        chk("frame_sticky", 32'(err), 1);
        // overrun during a held write, then reset mid-write
        do_reset();
        lat = 0;
        base = nwr;
        sb.push_back({32'h0, 32'ha5a5a5a5});
        send_word(32'ha5a5a5a5);
        wait_wr(base + 1);
        lat = 1000;
        sb.push_back({32'h4, 32'h12345678});
        send_word(32'h12345678);
        chk("hold_stb", 32'(stb), 1);
        chk("hold_adr4", adr, 32'h4);
        send_word(32'hcafef00d);
        chk("overrun_err", 32'(err), 1);
        chk("overrun_stb", 32'(stb), 1);
        rst_n = 0;
        #1;
        chk("midrst_stb", 32'(stb), 0);
        chk("midrst_debug", 32'(debug_mode), 1);
        chk("midrst_adr", adr, 0);
        chk("midrst_err", 32'(err), 0);
        @(negedge clk);
        sb.delete();
        rst_n = 1;
        lat = 1;
        base = nwr;
        sb.push_back({32'h0, 32'h0badf00d});
        send_word(32'h0badf00d);
        wait_wr(base + 1);
        // idle after one word and a partial word
        do_reset();
        lat = 0;
        base = nwr;
        sb.push_back({32'h0, 32'h11111111});
        send_word(32'h11111111);
        wait_wr(base + 1);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (300) @(negedge clk);
`ifdef SUBSERVIENT_LOADER_TIMEOUT_EN
        chk("timeout_done", 32'(done), 1);
`else
        chk("timeout_done", 32'(done), 0);
        chk("timeout_debug", 32'(debug_mode), 1);
`endif
        chk("timeout_nwr", 32'(nwr), 32'(base + 1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
